// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage and architectural register file with sticky halt.
// Optional same-cycle write-to-read forwarding: define REGFILE_WRITE_BYPASS_EN.
module writeback_regfile #(
  parameter int unsigned NREGS     = 15,
  parameter logic [3:0]  RSP_ID    = 4'd4,
  parameter logic [63:0] RSP_RESET = 64'h0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  w_icode,
  input  logic [3:0]  w_regA,
  input  logic [3:0]  w_regB,
  input  logic        w_cond,
  input  logic [63:0] w_valE,
  input  logic [63:0] w_valM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB,
  output logic [3:0]  w_dstE,
  output logic [3:0]  w_dstM,
  output logic        halted
);

  localparam logic [3:0] RegNone = 4'hF;

  localparam logic [3:0] IHalt   = 4'h0;
  localparam logic [3:0] IRrmovq = 4'h2;
  localparam logic [3:0] IIrmovq = 4'h3;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IOpq    = 4'h6;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPushq  = 4'hA;
  localparam logic [3:0] IPopq   = 4'hB;

  logic [63:0] regs_q [NREGS];
  logic        halted_q;
  logic        wr_en;

  always_comb begin
    w_dstE = RegNone;
    case (w_icode)
      IRrmovq:                     w_dstE = w_cond ? w_regB : RegNone;
      IIrmovq, IOpq:               w_dstE = w_regB;
      ICall, IRet, IPushq, IPopq:  w_dstE = RSP_ID;
      default:                     w_dstE = RegNone;
    endcase
  end

  always_comb begin
    w_dstM = RegNone;
    case (w_icode)
      IMrmovq, IPopq: w_dstM = w_regA;
      default:        w_dstM = RegNone;
    endcase
  end

  assign wr_en  = resetn && !halted_q;
  assign halted = halted_q;

  // M is applied after E so that a shared destination (popq %rsp) takes valM.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      halted_q <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= (4'(i) == RSP_ID) ? RSP_RESET : 64'h0;
      end
    end else if (!halted_q) begin
      if (w_icode == IHalt) begin
        halted_q <= 1'b1;
      end
      for (int i = 0; i < int'(NREGS); i++) begin
        if (w_dstM == 4'(i)) begin
          regs_q[i] <= w_valM;
        end else if (w_dstE == 4'(i)) begin
          regs_q[i] <= w_valE;
        end
      end
    end
  end

  logic [63:0] stored_a, stored_b;

  always_comb begin
    stored_a = 64'h0;
    stored_b = 64'h0;
    if (d_srcA != RegNone && 32'(d_srcA) < NREGS) begin
      stored_a = regs_q[d_srcA];
    end
    if (d_srcB != RegNone && 32'(d_srcB) < NREGS) begin
      stored_b = regs_q[d_srcB];
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  always_comb begin
    d_valA = stored_a;
    d_valB = stored_b;
    if (wr_en && d_srcA != RegNone) begin
      if (w_dstM == d_srcA) begin
        d_valA = w_valM;
      end else if (w_dstE == d_srcA) begin
        d_valA = w_valE;
      end
    end
    if (wr_en && d_srcB != RegNone) begin
      if (w_dstM == d_srcB) begin
        d_valB = w_valM;
      end else if (w_dstE == d_srcB) begin
        d_valB = w_valE;
      end
    end
  end
`else
  logic unused_wr_en;
  assign unused_wr_en = wr_en;
  always_comb begin
    d_valA = stored_a;
    d_valB = stored_b;
  end
`endif

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Consumer end of the M->W pipeline register: takes the latched write-back bundle (icode, regA, regB, cond, valE, valM) and commits results into the Y86-64 architectural register file.
- Decodes dstE/dstM internally from the W-stage fields, then writes on the clock edge.
- Serves the decode stage through two combinational read ports.
- Tracks a sticky halt status once a halt instruction reaches write-back.

Parameters:
- NREGS, 15, number of architectural registers (IDs 0..14); ID 4'hF means "no register".
- RSP_ID, 4, register ID of %rsp.
- RSP_RESET, 64'h0, reset value loaded into %rsp; all other registers reset to 0.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- resetn  input  1  synchronous, active-low reset sampled on posedge clock.
- w_icode  input  4  W-stage instruction code.
- w_regA  input  4  W-stage rA field.
- w_regB  input  4  W-stage rB field.
- w_cond  input  1  W-stage condition result (used by cmovXX).
- w_valE  input  64  W-stage ALU result.
- w_valM  input  64  W-stage memory read result.
- d_srcA  input  4  decode read address A.
- d_srcB  input  4  decode read address B.
- d_valA  output  64  read data A; 0 when d_srcA==4'hF.
- d_valB  output  64  read data B; 0 when d_srcB==4'hF.
- w_dstE  output  4  decoded E-destination; visible to the forwarding logic.
- w_dstM  output  4  decoded M-destination; visible to the forwarding logic.
- halted  output  1  sticky halt flag.

Behaviour:
- Reset: resetn low at a posedge sets all registers to 0 except %rsp=RSP_RESET, and clears halted. No writes occur in a reset cycle. Reset applied mid-stream discards the pending W-stage write.
- dstE decode (combinational from W-stage fields):
  - cmovXX/rrmovq (2): regB if w_cond, else F.
  - irmovq (3) and OPq (6): regB.
  - call (8), ret (9), pushq (A), popq (B): RSP_ID.
  - All other icodes: F.
- dstM decode: mrmovq (5) and popq (B): regA; all other icodes: F.
- Write, on posedge when resetn=1 and halted=0:
  - reg[w_dstE] <= w_valE if w_dstE != F.
  - reg[w_dstM] <= w_valM if w_dstM != F.
  - Same-cycle collision (w_dstE==w_dstM, e.g. popq %rsp): valM wins.
- Halt: w_icode==0 at a posedge with halted=0 sets halted=1 on that edge. While halted=1, all writes are suppressed; only resetn clears it.
- Invalid destination: icodes C..F and ID F never write. ID values above NREGS-1 are excluded by NREGS=15.
- Reads: combinational from stored state, zero latency. Without the optional feature, a read issued in the same cycle as a write to that register returns the old value; the new value is visible the cycle after the edge.
- Outputs are idle-driven with no X after reset: d_valA/d_valB reflect the reset contents.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: d_valA/d_valB forward the same-cycle W write, so a write and read of the same register in one cycle returns the new value.
  - Priority: w_dstM match -> w_valM; else w_dstE match -> w_valE; else stored value.
  - Forwarding applies only when halted=0 and resetn=1.
- Undefined: reads return stored values only (old value on collision).

Test Plan:
- Reset: hold resetn=0 for 2 cycles with RSP_RESET=64'h100 -> d_srcA=4 reads 64'h100; d_srcB=0 reads 0; halted=0.
- irmovq: icode=3, regB=2, valE=64'h1234, then the next cycle an OPq with icode=6, regB=3, valE=64'h5 -> after the edges, reg2=64'h1234 and reg3=64'h5; the read of reg2 in the write cycle returns 0 without bypass, or 64'h1234 with REGFILE_WRITE_BYPASS_EN.
- cmovXX: icode=2, regB=1, cond=0, valE=64'hAA -> reg1 unchanged and w_dstE=F. Repeat with cond=1 -> reg1=64'hAA.
- popq %rsp: icode=B, regA=4, valE=64'h108, valM=64'hDEAD -> %rsp=64'hDEAD (M wins). Then popq with regA=0 -> %rsp=valE and reg0=valM.
- Halt: icode=0 at an edge, followed by irmovq to reg5 -> halted=1 and reg5 unchanged. Then resetn=0 for one edge -> halted=0.
- Mid-operation reset: resetn=0 in the same cycle as irmovq reg6=64'h77 -> reg6=0 after the edge.
